wino_atma_f43: RTL and testbench
================================

Name: wino_atma_f43

Overview:
- Winograd F(4x4,3x3) output transform Y = A^T·M·A.
- Sits downstream of the element-wise multiply stage. It is the inverse-direction counterpart of the B^T·d·B input transform.
- Accepts one 6-element row of a 6x6 product tile per handshake and emits the 4x4 spatial output tile one 4-element row per handshake.
- Valid/ready on both sides; single tile buffer; FILL/DRAIN sequencing.

Parameters:
- data_width, 23: signed two's-complement width of each input element din0..din5.
- mid_width, data_width+5: width of the row-transformed buffer entries. Max row gain is 20, and 20·2^22 < 2^27.
- out_width, data_width+9: width of each output element. Max tile gain is 400, and 400·2^22 < 2^31, so there is no overflow.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- din_valid  in  1  input row valid.
- din_ready  out  1  block can accept an input row.
- din0..din5  in  data_width each  row r of M, columns 0..5, signed.
- dout_valid  out  1  output row valid.
- dout_ready  in  1  downstream accepts output row.
- dout0..dout3  out  out_width each  row j of Y, columns 0..3, signed.
- dout_last  out  1  high with output row 3 of a tile.

Behaviour:
- A^T rows, shared by both stages:
  - [1 1 1 1 1 0]
  - [0 1 -1 2 -2 0]
  - [0 1 1 4 4 0]
  - [0 1 -1 8 -8 1]
- Row stage, combinational on din:
  - t_k = Σ_c A^T[k][c]·din_c, for k = 0..3.
  - Sign-extend to mid_width; result is exact.
  - On an input handshake (din_valid && din_ready), write t_0..t_3 into buf[row_cnt][0..3] and increment row_cnt.
- Column stage:
  - dout_k = Σ_r A^T[out_cnt][r]·buf[r][k], for k = 0..3.
  - Sign-extend to out_width; result is exact.
- States: FILL (reset state) and DRAIN.
- FILL:
  - din_ready = 1, dout_valid = 0, dout0..3 = 0, dout_last = 0.
  - row_cnt counts 0..5.
  - Handshake with row_cnt = 5 → state DRAIN, row_cnt = 0, out_cnt = 0.
- DRAIN:
  - din_ready = 0, dout_valid = 1, dout_last = (out_cnt == 3).
  - Output handshake (dout_ready = 1): out_cnt increments.
  - Output handshake with out_cnt = 3 → state FILL, out_cnt = 0.
- Latency: last input row accepted at edge t → output row 0 valid in the cycle after t. A tile takes 6 + 4 = 10 cycles at full throughput.
- Backpressure: while dout_valid && !dout_ready, dout0..3 and dout_last are held stable. The buffer is not written in DRAIN.
- din_valid in DRAIN: ignored, no state change. The upstream must hold the row until din_ready returns.
- First din_ready after a drain: asserted in the cycle after the row-3 output handshake. There is no same-cycle overlap of drain and fill.
- dout_valid does not depend combinationally on dout_ready.
- Reset, at any time including mid-fill or mid-drain, forces the following immediately and asynchronously:
  - state FILL, row_cnt 0, out_cnt 0.
  - dout_valid 0, dout0..3 0, dout_last 0.
  - Buffer contents are don't-care and are overwritten by the next tile.
- Partial tiles are discarded on reset.

Decomposition:
- Package wino_f43_pkg holds:
  - the A^T coefficient constant (4x6, signed small ints);
  - the growth constants 5 and 9;
  - the FILL/DRAIN state enum.
- Sub-module wino_at_6to4, parameterised in/out widths, combinational 6-in/4-out A^T product:
  - one instance for the row stage;
  - four instances for the column stage, one per buffer column k, with output row selected by out_cnt.

Test Plan:
1. Impulse corner: M all zero except m[0][0] = 1, dout_ready = 1 → row0 = [1,0,0,0], rows1-3 all 0. dout_last only on row3. dout_valid in cycle after 6th input.
2. Impulse far corner: only m[5][5] = 1 → rows0-2 = 0, row3 = [0,0,0,1].
3. Centre tap: only m[3][3] = 1 → row0 [1,2,4,8], row1 [2,4,8,16], row2 [4,8,16,32], row3 [8,16,32,64].
4. All m = -1 → row0 [-25,0,-50,-5], row1 [0,0,0,0], row2 [-50,0,-100,-10], row3 [-5,0,-10,-1]. Same tile with all m = -2^22 → row2 col2 = -100·2^22 with no wrap.
5. Backpressure: dout_ready low 3 cycles on row1 → row1 held unchanged, din_ready stays 0. After the row3 handshake, din_ready = 1 the next cycle. din_valid held high during DRAIN causes no write.
6. Reset mid-fill: 3 rows accepted, rst pulsed → din_ready = 1, dout_valid = 0. The next 6 rows (tile of test 3) produce exactly test 3's output.

Source files
------------

// File: rtl/wino_atma_f43_pkg.sv
// Shared constants for the Winograd F(4x4,3x3) output transform:
// the A^T coefficient matrix, word-growth amounts and the tile FSM states.
package wino_f43_pkg;

  localparam int ROW_GROWTH  = 5;
  localparam int TILE_GROWTH = 9;

  localparam logic signed [4:0] AT_COEF [4][6] = '{
    '{ 5'sd1,  5'sd1,  5'sd1,  5'sd1,  5'sd1,  5'sd0},
    '{ 5'sd0,  5'sd1, -5'sd1,  5'sd2, -5'sd2,  5'sd0},
    '{ 5'sd0,  5'sd1,  5'sd1,  5'sd4,  5'sd4,  5'sd0},
    '{ 5'sd0,  5'sd1, -5'sd1,  5'sd8, -5'sd8,  5'sd1}
  };

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/wino_atma_f43_if.sv
// Row-in / row-out valid-ready bundle of the F(4x4,3x3) output transform.
interface wino_atma_f43_if import wino_f43_pkg::*; #(
  parameter int DATA_W = 23
);
  localparam int OUT_W = DATA_W + TILE_GROWTH;

  logic                     din_valid;
  logic                     din_ready;
  logic signed [DATA_W-1:0] din0, din1, din2, din3, din4, din5;
  logic                     dout_valid;
  logic                     dout_ready;
  logic signed [OUT_W-1:0]  dout0, dout1, dout2, dout3;
  logic                     dout_last;

  modport master (
    output din_valid, din0, din1, din2, din3, din4, din5, dout_ready,
    input  din_ready, dout_valid, dout0, dout1, dout2, dout3, dout_last
  );

  modport slave (
    input  din_valid, din0, din1, din2, din3, din4, din5, dout_ready,
    output din_ready, dout_valid, dout0, dout1, dout2, dout3, dout_last
  );
endinterface

// File: rtl/wino_atma_f43_at6to4.sv
// Combinational 6-in / 4-out product with A^T; OUT_W must cover the gain
// (at most 20) so every sum is exact.
module wino_at_6to4 import wino_f43_pkg::*; #(
  parameter int IN_W  = 23,
  parameter int OUT_W = 28
) (
  input  logic signed [IN_W-1:0]  x [6],
  output logic signed [OUT_W-1:0] y [4]
);

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      y[k] = '0;
      for (int c = 0; c < 6; c++) begin
        y[k] = y[k] + OUT_W'(x[c]) * OUT_W'(AT_COEF[k][c]);
      end
    end
  end

endmodule

// File: rtl/wino_atma_f43.sv
// Winograd F(4x4,3x3) output transform Y = A^T*M*A: six product rows fill a
// row-transformed tile buffer, then four output rows drain from it.
module wino_atma_f43 import wino_f43_pkg::*; #(
  parameter int DATA_W = 23
) (
  input  logic              clk,
  input  logic              rst,
  wino_atma_f43_if.slave    bus
);

  localparam int MID_W = DATA_W + ROW_GROWTH;
  localparam int OUT_W = DATA_W + TILE_GROWTH;

  state_t     state;
  logic [2:0] row_cnt;
  logic [1:0] out_cnt;
  logic       accept;
  logic       vld_p0;

  logic signed [DATA_W-1:0] din_vec [6];
  logic signed [MID_W-1:0]  t_row   [4];
  logic signed [MID_W-1:0]  tile_p0 [6][4];
  logic signed [MID_W-1:0]  col_in  [4][6];
  logic signed [OUT_W-1:0]  col_out [4][4];

  assign din_vec[0] = bus.din0;
  assign din_vec[1] = bus.din1;
  assign din_vec[2] = bus.din2;
  assign din_vec[3] = bus.din3;
  assign din_vec[4] = bus.din4;
  assign din_vec[5] = bus.din5;

  assign accept = bus.din_valid && (state == FILL);

  // Row stage: A^T applied to the incoming product row
  wino_at_6to4 #(.IN_W(DATA_W), .OUT_W(MID_W)) u_row (
    .x (din_vec),
    .y (t_row)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < 4; k++) begin
        tile_p0[row_cnt][k] <= t_row[k];
      end
    end
  end

  // Column stage: A^T applied down each buffer column, row picked by out_cnt
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < 6; r++) begin
        col_in[k][r] = tile_p0[r][k];
      end
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_col
    wino_at_6to4 #(.IN_W(MID_W), .OUT_W(OUT_W)) u_col (
      .x (col_in[k]),
      .y (col_out[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FILL;
      row_cnt <= '0;
      out_cnt <= '0;
    end else begin
      case (state)
        FILL: begin
          if (bus.din_valid) begin
            if (row_cnt == 3'd5) begin
              state   <= DRAIN;
              row_cnt <= '0;
              out_cnt <= '0;
            end else begin
              row_cnt <= row_cnt + 3'd1;
            end
          end
        end
        DRAIN: begin
          if (bus.dout_ready) begin
            out_cnt <= out_cnt + 2'd1;
            if (out_cnt == 2'd3) state <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // Outputs decode straight from registered state; the buffer is frozen in DRAIN
  assign vld_p0         = (state == DRAIN);
  assign bus.din_ready  = (state == FILL);
  assign bus.dout_valid = vld_p0;
  assign bus.dout_last  = vld_p0 && (out_cnt == 2'd3);
  assign bus.dout0      = vld_p0 ? col_out[0][out_cnt] : '0;
  assign bus.dout1      = vld_p0 ? col_out[1][out_cnt] : '0;
  assign bus.dout2      = vld_p0 ? col_out[2][out_cnt] : '0;
  assign bus.dout3      = vld_p0 ? col_out[3][out_cnt] : '0;

endmodule

// File: tb/tb_wino_atma_f43.sv
// Randomised bench for wino_atma_f43 against a direct Y = A^T*M*A model.
module tb_wino_atma_f43;

  localparam int DATA_W = 23;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wino_atma_f43_if #(.DATA_W(DATA_W)) bus ();

  wino_atma_f43 #(.DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  int at [4][6] = '{
    '{1, 1,  1, 1,  1, 0},
    '{0, 1, -1, 2, -2, 0},
    '{0, 1,  1, 4,  4, 0},
    '{0, 1, -1, 8, -8, 1}
  };

  longint m [6][6];

  task automatic check(string tag, longint obs, longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic longint y_ref(int i, int j);
    longint s = 0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        s += longint'(at[i][r]) * m[r][c] * longint'(at[j][c]);
    return s;
  endfunction

  function automatic longint dout_at(int k);
    case (k)
      0: return longint'(bus.dout0);
      1: return longint'(bus.dout1);
      2: return longint'(bus.dout2);
      default: return longint'(bus.dout3);
    endcase
  endfunction

  task automatic fill_const(longint v);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) m[r][c] = v;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        m[r][c] = longint'($urandom_range(0, (1 << DATA_W) - 1)) - (longint'(1) <<< (DATA_W - 1));
  endtask

  task automatic set_din(int r);
    bus.din0 = DATA_W'(m[r][0]);
    bus.din1 = DATA_W'(m[r][1]);
    bus.din2 = DATA_W'(m[r][2]);
    bus.din3 = DATA_W'(m[r][3]);
    bus.din4 = DATA_W'(m[r][4]);
    bus.din5 = DATA_W'(m[r][5]);
  endtask

  task automatic set_din_junk();
    bus.din0 = DATA_W'($urandom);
    bus.din1 = DATA_W'($urandom);
    bus.din2 = DATA_W'($urandom);
    bus.din3 = DATA_W'($urandom);
    bus.din4 = DATA_W'($urandom);
    bus.din5 = DATA_W'($urandom);
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that took the last row.
  task automatic feed(int n, bit gaps);
    for (int r = 0; r < n; r++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.din_valid = 1'b0;
          set_din_junk();
          @(posedge clk); #1;
        end
      end
      bus.din_valid = 1'b1;
      set_din(r);
      for (int w = 0; w < 20 && !bus.din_ready; w++) begin
        @(posedge clk); #1;
      end
      if (!bus.din_ready) check("din_ready_timeout", 0, 1);
      @(posedge clk); #1;
    end
    bus.din_valid = 1'b0;
  endtask

  task automatic drain(bit bp, bit hold_valid);
    check("first_valid", bus.dout_valid, 1);
    for (int j = 0; j < 4; j++) begin
      if (hold_valid) begin
        bus.din_valid = 1'b1;
        set_din_junk();
      end
      if (bp && j == 1) begin
        bus.dout_ready = 1'b0;
        for (int h = 0; h < 3; h++) begin
          @(posedge clk); #1;
          check("bp_valid", bus.dout_valid, 1);
          check("bp_din_ready", bus.din_ready, 0);
          check("bp_last", bus.dout_last, 0);
          for (int k = 0; k < 4; k++) check($sformatf("bp_hold_r1c%0d", k), dout_at(k), y_ref(1, k));
        end
      end
      bus.dout_ready = 1'b1;
      check($sformatf("valid_r%0d", j), bus.dout_valid, 1);
      check($sformatf("last_r%0d", j), bus.dout_last, (j == 3) ? 1 : 0);
      for (int k = 0; k < 4; k++)
        check($sformatf("y_r%0dc%0d", j, k), dout_at(k), y_ref(j, k));
      if (j < 3) check($sformatf("drain_din_ready_r%0d", j), bus.din_ready, 0);
      @(posedge clk); #1;
    end
    bus.din_valid = 1'b0;
    check("refill_din_ready", bus.din_ready, 1);
    check("refill_valid", bus.dout_valid, 0);
    check("refill_last", bus.dout_last, 0);
    check("refill_dout0", dout_at(0), 0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b0;
    set_din_junk();
    #12;
    check("rst_din_ready", bus.din_ready, 1);
    check("rst_valid", bus.dout_valid, 0);
    check("rst_last", bus.dout_last, 0);
    check("rst_dout3", dout_at(3), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    bus.dout_ready = 1'b1;

    fill_const(0); m[0][0] = 1;
    feed(6, 1'b0); drain(1'b0, 1'b0);

    fill_const(0); m[5][5] = 1;
    feed(6, 1'b0); drain(1'b0, 1'b0);

    fill_const(0); m[3][3] = 1;
    feed(6, 1'b0); drain(1'b0, 1'b0);

    fill_const(-1);
    feed(6, 1'b0); drain(1'b0, 1'b0);

    fill_const(-(longint'(1) <<< 22));
    feed(6, 1'b0); drain(1'b0, 1'b0);
    check("min_tile_ref", y_ref(2, 2), -100 * (longint'(1) <<< 22));

    fill_rand();
    feed(6, 1'b1); drain(1'b1, 1'b1);

    fill_rand();
    feed(3, 1'b1);
    rst = 1'b1;
    #1;
    check("midfill_rst_din_ready", bus.din_ready, 1);
    check("midfill_rst_valid", bus.dout_valid, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    fill_const(0); m[3][3] = 1;
    feed(6, 1'b0); drain(1'b0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      fill_rand();
      feed(6, t[0]);
      drain(t[1], t[2]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
